twos_complement_to_int: RTL and testbench
=========================================

// Module: twos_complement_to_int
// PURPOSE
//   Registered two's-complement to magnitude converter.
//   - Output: unsigned magnitude plus sign of a signed WIDTH-bit value.
//   - Used by the FPU control unit to turn signed bit-position distances and
//     small-ALU exponent differences into shift and increment amounts.
//   - The sign output selects the shift direction (right/left).
// PARAMETERS
//   WIDTH  64  operand and result width in bits; legal range 2 to 64
// PORTS
//   clk                  in   1      rising-edge clock
//   reset                in   1      asynchronous, active-low reset
//   in_valid             in   1      TwosComplementValue is valid this cycle
//   TwosComplementValue  in   WIDTH  signed two's-complement operand
//   result               out  WIDTH  unsigned magnitude |TwosComplementValue|
//   sign                 out  1      MSB of the captured operand (1 = negative)
//   overflow             out  1      operand was -2^(WIDTH-1)
//   out_valid            out  1      result/sign/overflow valid this cycle
// BEHAVIOUR
//   - Reset (reset=0, async assert, sync release):
//     result=0, sign=0, overflow=0, out_valid=0.
//   - Latency is 1 cycle. Inputs sampled on rising clk with in_valid=1 appear
//     on the outputs in the next cycle with out_valid=1.
//   - Throughput is 1 per cycle. No backpressure and no ready signal.
//   - in_valid=0: out_valid drops to 0 on the next edge.
//     result, sign and overflow hold their last values.
//   - Arithmetic, with v = TwosComplementValue:
//     - v[WIDTH-1]=0: result = v.
//     - v[WIDTH-1]=1: result = (~v)+1, truncated to WIDTH bits.
//     - sign = v[WIDTH-1].
//   - Boundary cases:
//     - v=0: result=0, sign=0, overflow=0.
//     - v=-1 (all ones): result=1, sign=1.
//     - v=-2^(WIDTH-1): overflow=1, sign=1. result depends on the macro
//       (see CONFIGURATION).
//     - v=+2^(WIDTH-1)-1: result=v, overflow=0.
//   - Narrow callers sign-extend to WIDTH before driving the port
//     (e.g. a 23-bit distance or an 8-bit exponent difference).
//     Only result[7:0] or result[22:0] are consumed in those cases.
//   - Reset asserted mid-stream: outputs clear immediately. The in-flight
//     operand is discarded. The first valid after release takes 1 cycle.
//   - No internal state beyond the output registers. No X propagation from an
//     idle input: when in_valid=0 the output registers are not loaded.
// CONFIGURATION
//   TWOS_TO_INT_SATURATE_EN
//     - Defined: for v=-2^(WIDTH-1), result = 2^(WIDTH-1)-1
//       (saturates to the maximum positive signed value). overflow=1.
//     - Undefined (default): result = 2^(WIDTH-1)
//       (exact unsigned magnitude, e.g. 64'h8000_0000_0000_0000). overflow=1.
//     - All other inputs are identical in both builds.
// TESTING
//   - Reset: hold reset=0 with random inputs -> result=0, sign=0, overflow=0,
//     out_valid=0. Release, then drive in_valid=1, v=5 -> next cycle result=5,
//     sign=0, out_valid=1.
//   - Negative: v=64'hFFFF_FFFF_FFFF_FFFD (-3) -> result=3, sign=1, overflow=0
//     after 1 cycle.
//   - Sign-extended 23-bit: v = sext(23'h7FFFFE) (-2) -> result=2, sign=1.
//     Sign-extended 8-bit: v = sext(8'h80) (-128) -> result=128.
//   - Most-negative: v=64'h8000_0000_0000_0000 -> overflow=1, sign=1.
//     result=64'h8000_0000_0000_0000 without the macro,
//     64'h7FFF_FFFF_FFFF_FFFF with TWOS_TO_INT_SATURATE_EN.
//   - Streaming: back-to-back valids 0, -1, +7, -7 -> results 0, 1, 7, 7 on
//     consecutive cycles. A following in_valid=0 cycle -> out_valid=0 and
//     result holds 7.
//   - Async reset mid-stream: assert reset between clock edges -> outputs clear
//     before the next edge. In-flight data is not output after release.

Source files
------------

// File: rtl/twos_complement_to_int.sv
// Registered two's-complement to magnitude/sign converter with one-cycle latency.
// Define TWOS_TO_INT_SATURATE_EN to clamp the most-negative operand to the largest positive value.
module twos_complement_to_int #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] TwosComplementValue,
  output logic [WIDTH-1:0] result,
  output logic             sign,
  output logic             overflow,
  output logic             out_valid
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             neg;
  logic             is_min;
  logic [WIDTH-1:0] magnitude;

  // Negating the most-negative value wraps back to itself, which is already
  // the exact unsigned magnitude; the saturating build substitutes MAX_POS.
  always_comb begin
    neg       = TwosComplementValue[WIDTH-1];
    is_min    = (TwosComplementValue == MIN_NEG);
    magnitude = neg ? (~TwosComplementValue) + ONE : TwosComplementValue;
`ifdef TWOS_TO_INT_SATURATE_EN
    if (is_min) magnitude = MAX_POS;
`else
    if (is_min) magnitude = MIN_NEG;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values. Data registers load only on in_valid, so an idle
  // (possibly X) input never reaches them and the last result is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result    <= '0;
      sign      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= magnitude;
        sign     <= neg;
        overflow <= is_min;
      end
    end
  end

endmodule

// File: tb/tb_twos_complement_to_int.sv
// Scoreboard bench for twos_complement_to_int (WIDTH=64); honours TWOS_TO_INT_SATURATE_EN.
module tb_twos_complement_to_int;

  typedef struct packed {
    logic [63:0] res;
    logic        sgn;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] value;
  logic [63:0] result;
  logic        sign;
  logic        overflow;
  logic        out_valid;

  exp_t sb[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  twos_complement_to_int #(.WIDTH(64)) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .TwosComplementValue (value),
    .result              (result),
    .sign                (sign),
    .overflow            (overflow),
    .out_valid           (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] v);
    exp_t e;
    logic signed [63:0] s;
    s     = v;
    e.sgn = (s < 0);
    e.ovf = (v == 64'h8000_0000_0000_0000);
    e.res = (s < 0) ? 64'(64'sd0 - s) : v;
`ifdef TWOS_TO_INT_SATURATE_EN
    if (e.ovf) e.res = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    return e;
  endfunction

  task automatic send(input logic [63:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    value    = v;
    sb.push_back(model(v));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      value    = {$urandom, $urandom};
    end
  endtask

  // Monitor: inputs sampled at the edge, outputs checked 1 ns later.
  always @(posedge clk) begin : monitor
    logic iv, rs;
    exp_t e;
    iv = in_valid;
    rs = reset;
    #1;
    if (rs) begin
      check("out_valid", {63'd0, out_valid}, {63'd0, iv});
      if (iv) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("sign", {63'd0, sign}, {63'd0, e.sgn});
          check("overflow", {63'd0, overflow}, {63'd0, e.ovf});
          last_exp = e;
        end
      end else begin
        check("hold_result", result, last_exp.res);
        check("hold_sign", {63'd0, sign}, {63'd0, last_exp.sgn});
      end
    end
  end

  task automatic check_cleared(input string tag);
    check({tag, "_result"}, result, 64'd0);
    check({tag, "_sign"}, {63'd0, sign}, 64'd0);
    check({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    last_exp = '0;
    reset    = 1'b0;
    in_valid = 1'b1;
    value    = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      value    = {$urandom, $urandom};
      #1 check_cleared("reset_hold");
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;

    send(64'd5);
    send(64'hFFFF_FFFF_FFFF_FFFD);
    send({{41{1'b1}}, 23'h7FFFFE});
    send({{56{1'b1}}, 8'h80});
    send(64'h8000_0000_0000_0000);
    send(64'h7FFF_FFFF_FFFF_FFFF);
    idle(1);

    // Streaming then idle hold
    send(64'd0);
    send(64'hFFFF_FFFF_FFFF_FFFF);
    send(64'd7);
    send(64'hFFFF_FFFF_FFFF_FFF9);
    idle(2);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send({$urandom, $urandom});
    end
    idle(1);

    // Async reset with an operand in flight
    send(64'd11);
    send(64'hFFFF_FFFF_FFFF_FFF4);
    #2 reset = 1'b0;
    sb.delete();
    last_exp = '0;
    #1 check_cleared("async_reset");
    @(negedge clk);
    in_valid = 1'b0;
    #1 check_cleared("reset_edge");
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    send(64'd5);
    send(64'h8000_0000_0000_0000);
    idle(2);

    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
